// File: rtl/clkrst_ctrl_if.sv
// Run-control bundle between clkrst_ctrl and the core/board side.
// master: the controller; slave: the core or bench driving status inputs.
interface clkrst_ctrl_if #(
  parameter int unsigned NUM_ERR = 4,
  parameter int unsigned CNT_W   = 32
);
  logic [NUM_ERR-1:0] err;
  logic               retire;
  logic               halt;
  logic               core_rst;
  logic               running;
  logic               done;
  logic               pass;
  logic               fail;
  logic [1:0]         fail_cause;
  logic [NUM_ERR-1:0] err_src;
  logic [CNT_W-1:0]   cycle_count;

  modport master (
    input  err, retire, halt,
    output core_rst, running, done, pass, fail, fail_cause, err_src, cycle_count
  );

  modport slave (
    output err, retire, halt,
    input  core_rst, running, done, pass, fail, fail_cause, err_src, cycle_count
  );
endinterface

// File: rtl/clkrst_ctrl.sv
// Run controller: synchronized, stretched core reset, run-cycle counting and a
// sticky PASS/FAIL verdict from error channels, halt, timeout and retire stall.
module clkrst_ctrl #(
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MAX_CYCLES  = 100004,
  parameter int unsigned STALL_LIMIT = 1024,
  parameter int unsigned NUM_ERR     = 4,
  parameter int unsigned CNT_W       = 32
) (
  input logic           clk,
  input logic           rst_n,
  clkrst_ctrl_if.master bus_io
);

  typedef enum logic [1:0] {StHold, StRun, StPass, StFail} state_e;

  localparam int unsigned      HoldW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast     = HoldW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MaxCnt       = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] StallCnt     = CNT_W'(STALL_LIMIT);
  localparam logic [1:0]       CauseNone    = 2'b00;
  localparam logic [1:0]       CauseErr     = 2'b01;
  localparam logic [1:0]       CauseTimeout = 2'b10;
  localparam logic [1:0]       CauseStall   = 2'b11;

  state_e             state_q, state_d;
  logic [1:0]         sync_q, sync_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d, cycle_inc;
  logic [CNT_W-1:0]   stall_q, stall_d, stall_inc;
  logic [1:0]         cause_q, cause_d;
  logic [NUM_ERR-1:0] src_q, src_d;
  logic               core_rst_q, core_rst_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHold;
      sync_q     <= 2'b00;
      hold_q     <= '0;
      cycle_q    <= '0;
      stall_q    <= '0;
      cause_q    <= CauseNone;
      src_q      <= '0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hold_q     <= hold_d;
      cycle_q    <= cycle_d;
      stall_q    <= stall_d;
      cause_q    <= cause_d;
      src_q      <= src_d;
      core_rst_q <= core_rst_d;
      running_q  <= running_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], 1'b1};
    hold_d  = hold_q;
    cycle_d = cycle_q;
    stall_d = stall_q;
    cause_d = cause_q;
    src_d   = src_q;
    // Saturating increments; timeout normally fires long before the cycle counter fills.
    cycle_inc = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
    stall_inc = bus_io.retire ? '0 : ((&stall_q) ? stall_q : stall_q + CNT_W'(1));

    unique case (state_q)
      StHold: begin
        if (sync_q[1]) begin
          if (hold_q == HoldLast) state_d = StRun;
          else                    hold_d  = hold_q + HoldW'(1);
        end
      end
      StRun: begin
        cycle_d = cycle_inc;
        stall_d = stall_inc;
        if (|bus_io.err) begin
          state_d = StFail;
          cause_d = CauseErr;
          src_d   = bus_io.err;
        end else if (bus_io.halt) begin
          state_d = StPass;
        end else if ((MAX_CYCLES != 0) && (cycle_inc == MaxCnt)) begin
          state_d = StFail;
          cause_d = CauseTimeout;
        end else if ((STALL_LIMIT != 0) && (stall_inc == StallCnt)) begin
          state_d = StFail;
          cause_d = CauseStall;
        end
      end
      default: ;
    endcase

    core_rst_d = (state_d == StHold);
    running_d  = (state_d == StRun);
    done_d     = (state_d == StPass) || (state_d == StFail);
    pass_d     = (state_d == StPass);
    fail_d     = (state_d == StFail);
  end

  assign bus_io.core_rst    = core_rst_q;
  assign bus_io.running     = running_q;
  assign bus_io.done        = done_q;
  assign bus_io.pass        = pass_q;
  assign bus_io.fail        = fail_q;
  assign bus_io.fail_cause  = cause_q;
  assign bus_io.err_src     = src_q;
  assign bus_io.cycle_count = cycle_q;

endmodule

// File: tb/tb_clkrst_ctrl.sv
// Bench for clkrst_ctrl: three differently parameterised instances share stimulus and are
// compared every cycle against an edge-counting reference model, plus fixed expectations.
module tb_clkrst_ctrl;

  localparam int     NI          = 3;
  localparam int     RSTC  [NI]  = '{2, 2, 3};
  localparam longint MAXC  [NI]  = '{100004, 20, 0};
  localparam longint STLC  [NI]  = '{1024, 8, 0};
  localparam longint SATC  [NI]  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 255};
  localparam logic [4:0] FL_HOLD = 5'b10000;  // {core_rst, running, done, pass, fail}
  localparam logic [4:0] FL_RUN  = 5'b01000;
  localparam logic [4:0] FL_PASS = 5'b00110;
  localparam logic [4:0] FL_FAIL = 5'b00101;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [3:0] err    = 4'd0;
  logic       retire = 1'b0;
  logic       halt   = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  clkrst_ctrl_if #(.NUM_ERR(4), .CNT_W(32)) if0 ();
  clkrst_ctrl_if #(.NUM_ERR(4), .CNT_W(32)) if1 ();
  clkrst_ctrl_if #(.NUM_ERR(4), .CNT_W(8))  if2 ();

  clkrst_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(100004), .STALL_LIMIT(1024), .NUM_ERR(4),
                .CNT_W(32)) u0 (.clk(clk), .rst_n(rst_n), .bus_io(if0));
  clkrst_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(20), .STALL_LIMIT(8), .NUM_ERR(4),
                .CNT_W(32)) u1 (.clk(clk), .rst_n(rst_n), .bus_io(if1));
  clkrst_ctrl #(.RST_CYCLES(3), .MAX_CYCLES(0), .STALL_LIMIT(0), .NUM_ERR(4),
                .CNT_W(8))  u2 (.clk(clk), .rst_n(rst_n), .bus_io(if2));

  assign if0.err = err;  assign if0.retire = retire;  assign if0.halt = halt;
  assign if1.err = err;  assign if1.retire = retire;  assign if1.halt = halt;
  assign if2.err = err;  assign if2.retire = retire;  assign if2.halt = halt;

  logic [4:0]  d_flags [NI];
  logic [1:0]  d_cause [NI];
  logic [3:0]  d_src   [NI];
  logic [63:0] d_cnt   [NI];
  assign d_flags[0] = {if0.core_rst, if0.running, if0.done, if0.pass, if0.fail};
  assign d_flags[1] = {if1.core_rst, if1.running, if1.done, if1.pass, if1.fail};
  assign d_flags[2] = {if2.core_rst, if2.running, if2.done, if2.pass, if2.fail};
  assign d_cause[0] = if0.fail_cause;  assign d_src[0] = if0.err_src;
  assign d_cause[1] = if1.fail_cause;  assign d_src[1] = if1.err_src;
  assign d_cause[2] = if2.fail_cause;  assign d_src[2] = if2.err_src;
  assign d_cnt[0]   = 64'(if0.cycle_count);
  assign d_cnt[1]   = 64'(if1.cycle_count);
  assign d_cnt[2]   = 64'(if2.cycle_count);

  // Reference model: edges since release, run cycles, cycles since retire, verdict 0/1/2.
  int         m_edges   [NI] = '{default: 0};
  longint     m_cyc     [NI] = '{default: 0};
  longint     m_stall   [NI] = '{default: 0};
  int         m_verdict [NI] = '{default: 0};
  int         m_cause   [NI] = '{default: 0};
  logic [3:0] m_src     [NI] = '{default: 4'd0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_edges[i] = 0; m_cyc[i] = 0; m_stall[i] = 0;
        m_verdict[i] = 0; m_cause[i] = 0; m_src[i] = 4'd0;
      end else if (m_edges[i] < 2 + RSTC[i]) begin
        m_edges[i]++;
      end else if (m_verdict[i] == 0) begin
        m_cyc[i]   = (m_cyc[i] < SATC[i]) ? m_cyc[i] + 1 : m_cyc[i];
        m_stall[i] = retire ? 0 : m_stall[i] + 1;
        if (err != 4'd0) begin
          m_verdict[i] = 2; m_cause[i] = 1; m_src[i] = err;
        end else if (halt) begin
          m_verdict[i] = 1;
        end else if (MAXC[i] != 0 && m_cyc[i] == MAXC[i]) begin
          m_verdict[i] = 2; m_cause[i] = 2;
        end else if (STLC[i] != 0 && m_stall[i] == STLC[i]) begin
          m_verdict[i] = 2; m_cause[i] = 3;
        end
      end
    end
  end

  function automatic logic [4:0] exp_flags(input int i);
    logic cr;
    cr = (m_edges[i] < 2 + RSTC[i]);
    return {cr, !cr && m_verdict[i] == 0, m_verdict[i] != 0, m_verdict[i] == 1,
            m_verdict[i] == 2};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.flags", i), 64'(d_flags[i]), 64'(exp_flags(i)));
      check($sformatf("u%0d.fail_cause", i), 64'(d_cause[i]), 64'(m_cause[i]));
      check($sformatf("u%0d.err_src", i), 64'(d_src[i]), 64'(m_src[i]));
      check($sformatf("u%0d.cycle_count", i), d_cnt[i], 64'(m_cyc[i]));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves rst_n high at a falling edge; the next rising edge is release edge 1.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_u%0d_flags", tag, i), 64'(d_flags[i]), 64'(FL_HOLD));
      check($sformatf("%s_u%0d_cnt", tag, i), d_cnt[i], 64'd0);
      check($sformatf("%s_u%0d_cause", tag, i), 64'(d_cause[i]), 64'd0);
      check($sformatf("%s_u%0d_src", tag, i), 64'(d_src[i]), 64'd0);
    end
  endtask

  initial begin
    // Reset release timing.
    do_reset();
    retire = 1'b1;
    run(3);
    check("rst_e3_hold", 64'(d_flags[0]), 64'(FL_HOLD));
    run(1);
    check("rst_e4_run", 64'(d_flags[0]), 64'(FL_RUN));
    check("rst_e4_cnt0", d_cnt[0], 64'd0);
    check("rst_e4_u2_hold", 64'(d_flags[2]), 64'(FL_HOLD));
    run(1);
    check("rst_e5_cnt1", d_cnt[0], 64'd1);
    check_async_reset("async1");

    // Clean pass on RUN edge 10.
    do_reset();
    retire = 1'b1;
    run(13);
    halt = 1'b1;
    run(1);
    halt = 1'b0;
    check("pass_flags", 64'(d_flags[0]), 64'(FL_PASS));
    check("pass_cause", 64'(d_cause[0]), 64'd0);
    check("pass_cnt", d_cnt[0], 64'd10);
    run(20);
    check("pass_frozen_cnt", d_cnt[0], 64'd10);
    check("pass_frozen_flags", 64'(d_flags[0]), 64'(FL_PASS));

    // Error during HOLD ignored; error beats halt on RUN edge 5.
    do_reset();
    err = 4'b1111;
    retire = 1'b1;
    run(4);
    err = 4'd0;
    check("hold_err_ignored", 64'(d_flags[0]), 64'(FL_RUN));
    run(4);
    err = 4'b0100;
    halt = 1'b1;
    run(1);
    err = 4'd0;
    halt = 1'b0;
    check("err_flags", 64'(d_flags[0]), 64'(FL_FAIL));
    check("err_cause", 64'(d_cause[0]), 64'd1);
    check("err_src", 64'(d_src[0]), 64'h4);
    check("err_cnt", d_cnt[0], 64'd5);
    run(5);
    check("err_frozen_cnt", d_cnt[0], 64'd5);

    // Timeout on u1 at 20, no timeout on u2 with its counter saturating.
    do_reset();
    retire = 1'b0;
    for (int k = 0; k < 30; k++) begin
      retire = ~retire;
      run(1);
    end
    check("tmo_u1_flags", 64'(d_flags[1]), 64'(FL_FAIL));
    check("tmo_u1_cause", 64'(d_cause[1]), 64'd2);
    check("tmo_u1_cnt", d_cnt[1], 64'd20);
    check("tmo_u0_cnt", d_cnt[0], 64'd26);
    for (int k = 0; k < 260; k++) begin
      retire = ~retire;
      run(1);
    end
    check("sat_u2_flags", 64'(d_flags[2]), 64'(FL_RUN));
    check("sat_u2_cnt", d_cnt[2], 64'd255);
    check("long_u0_cnt", d_cnt[0], 64'd286);

    // Stall: retire only on RUN edge 3.
    do_reset();
    retire = 1'b0;
    run(6);
    retire = 1'b1;
    run(1);
    retire = 1'b0;
    run(7);
    check("stall_u1_pre", 64'(d_flags[1]), 64'(FL_RUN));
    run(1);
    check("stall_u1_flags", 64'(d_flags[1]), 64'(FL_FAIL));
    check("stall_u1_cause", 64'(d_cause[1]), 64'd3);
    check("stall_u1_cnt", d_cnt[1], 64'd11);

    // A retire on RUN edge 9 restarts the stall window.
    do_reset();
    retire = 1'b0;
    run(6);
    retire = 1'b1;
    run(1);
    retire = 1'b0;
    run(5);
    retire = 1'b1;
    run(1);
    retire = 1'b0;
    run(7);
    check("restart_u1_pre", 64'(d_flags[1]), 64'(FL_RUN));
    run(1);
    check("restart_u1_cause", 64'(d_cause[1]), 64'd3);
    check("restart_u1_cnt", d_cnt[1], 64'd17);

    // Mid-run reset after 50 RUN cycles, then a full rerun ending in halt on RUN edge 3.
    do_reset();
    retire = 1'b1;
    run(54);
    check("mid_u0_cnt50", d_cnt[0], 64'd50);
    check_async_reset("async2");
    do_reset();
    run(6);
    halt = 1'b1;
    run(1);
    halt = 1'b0;
    check("rerun_flags", 64'(d_flags[0]), 64'(FL_PASS));
    check("rerun_cnt", d_cnt[0], 64'd3);

    // Randomised rounds, checked every cycle by the model.
    for (int r = 0; r < 25; r++) begin
      int len;
      int lazy;
      do_reset();
      len  = int'($urandom_range(20, 400));
      lazy = int'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        err    = ($urandom_range(0, 199) == 0) ? 4'($urandom) : 4'd0;
        halt   = ($urandom_range(0, 299) == 0);
        retire = lazy != 0 ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 299) == 0) begin
          #2 rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
        end else begin
          run(1);
        end
      end
      err = 4'd0;
      halt = 1'b0;
    end

    run(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
